// File: rtl/ad7276_emu_pkg.sv
// Shared state encoding and constants for the AD7276 ADC serial-interface emulator.
package ad7276_emu_pkg;

  localparam int DEFAULT_LEAD_ZEROS = 2;
  localparam int UNDERRUN_CNT_W     = 16;

  typedef enum logic [1:0] {
    IDLE,
    LEAD,
    DATA,
    TRAIL
  } emu_state_t;

  // Event counters stick at all-ones instead of wrapping.
  function automatic logic [UNDERRUN_CNT_W-1:0] sat_inc(input logic [UNDERRUN_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/ad7276_emu_sync_edge_det.sv
// Multi-stage synchronizer for one asynchronous pin, with registered one-cycle
// rise/fall pulses taken from the synchronized copy.
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic async_in,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Flops reset high so an idle-high line never produces a spurious edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= '1;
      prev_q <= 1'b1;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q[0] <= async_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev_q <= sync_q[SYNC_STAGES-1];
      rise   <= ~prev_q &  sync_q[SYNC_STAGES-1];
      fall   <=  prev_q & ~sync_q[SYNC_STAGES-1];
    end
  end

endmodule

// File: rtl/ad7276_emu.sv
// AD7276 serial ADC emulator: serializes held samples on the master's cs/sclk.
// Optional ramp test pattern is enabled with `define AD7276_EMU_TEST_PATTERN_EN.
module ad7276_emu
  import ad7276_emu_pkg::*;
#(
  parameter int ADC_LENGTH  = 12,
  parameter int LEAD_ZEROS  = DEFAULT_LEAD_ZEROS,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      CLK100MHz,
  input  logic                      RESET,
`ifdef AD7276_EMU_TEST_PATTERN_EN
  input  logic                      tp_en,
`endif
  input  logic [ADC_LENGTH-1:0]     s_tdata,
  input  logic                      s_tvalid,
  output logic                      s_tready,
  input  logic                      cs,
  input  logic                      sclk,
  output logic                      sdata,
  output logic                      sdata_oe,
  output logic                      busy,
  output logic                      frame_done,
  output logic                      underrun,
  output logic [UNDERRUN_CNT_W-1:0] underrun_cnt
);

  localparam int              CNT_W     = $clog2(ADC_LENGTH + LEAD_ZEROS + 1);
  localparam logic [CNT_W-1:0] LEAD_LAST = CNT_W'(LEAD_ZEROS - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(ADC_LENGTH - 2);

  logic cs_rise, cs_fall, sclk_fall, sclk_rise_unused;

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_cs_sync (
    .clock    (CLK100MHz),
    .reset    (RESET),
    .async_in (cs),
    .rise     (cs_rise),
    .fall     (cs_fall)
  );

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_sync (
    .clock    (CLK100MHz),
    .reset    (RESET),
    .async_in (sclk),
    .rise     (sclk_rise_unused),
    .fall     (sclk_fall)
  );

  emu_state_t                state_q, state_d;
  logic [CNT_W-1:0]          bit_cnt_q, bit_cnt_d;
  logic [ADC_LENGTH-1:0]     shift_q, shift_d;
  logic [ADC_LENGTH-1:0]     sample_q, sample_d;
  logic [ADC_LENGTH-1:0]     last_q, last_d;
  logic                      full_q, full_d;
  logic                      sdata_q, sdata_d;
  logic                      oe_q, oe_d;
  logic                      fd_q, fd_d;
  logic                      ur_q, ur_d;
  logic [UNDERRUN_CNT_W-1:0] ucnt_q, ucnt_d;
  logic                      handshake;
`ifdef AD7276_EMU_TEST_PATTERN_EN
  logic [ADC_LENGTH-1:0]     ramp_q, ramp_d;

  assign s_tready = ~full_q & ~tp_en;
`else
  assign s_tready = ~full_q;
`endif

  assign handshake = s_tvalid & s_tready;

  // Next-state and datapath: frame sequencing, sample holding and underrun tracking.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    sample_d  = sample_q;
    last_d    = last_q;
    full_d    = full_q;
    sdata_d   = sdata_q;
    oe_d      = oe_q;
    fd_d      = 1'b0;
    ur_d      = 1'b0;
    ucnt_d    = ucnt_q;
`ifdef AD7276_EMU_TEST_PATTERN_EN
    ramp_d    = ramp_q;
`endif

    if (handshake) begin
      sample_d = s_tdata;
      full_d   = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d   = LEAD;
          bit_cnt_d = '0;
          sdata_d   = 1'b0;
          oe_d      = 1'b1;
`ifdef AD7276_EMU_TEST_PATTERN_EN
          if (tp_en) begin
            shift_d = ramp_q;
            ramp_d  = ramp_q + 1'b1;
          end else
`endif
          if (full_q) begin
            shift_d = sample_q;
            last_d  = sample_q;
            full_d  = 1'b0;
          end else if (handshake) begin
            // A sample arriving exactly at frame start goes straight to the shifter.
            shift_d = s_tdata;
            last_d  = s_tdata;
            full_d  = 1'b0;
          end else begin
            shift_d = last_q;
            ur_d    = 1'b1;
            ucnt_d  = sat_inc(ucnt_q);
          end
        end
      end

      LEAD: begin
        if (cs_rise) begin
          state_d = IDLE;
          oe_d    = 1'b0;
          sdata_d = 1'b0;
        end else if (sclk_fall) begin
          if (bit_cnt_q == LEAD_LAST) begin
            state_d   = DATA;
            bit_cnt_d = '0;
            sdata_d   = shift_q[ADC_LENGTH-1];
            shift_d   = shift_q << 1;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            sdata_d   = 1'b0;
          end
        end
      end

      DATA: begin
        if (cs_rise) begin
          state_d = IDLE;
          oe_d    = 1'b0;
          sdata_d = 1'b0;
        end else if (sclk_fall) begin
          sdata_d = shift_q[ADC_LENGTH-1];
          shift_d = shift_q << 1;
          if (bit_cnt_q == DATA_LAST) begin
            state_d = TRAIL;
            fd_d    = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end

      TRAIL: begin
        if (cs_rise) begin
          state_d = IDLE;
          oe_d    = 1'b0;
          sdata_d = 1'b0;
        end else if (sclk_fall) begin
          sdata_d = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
        oe_d    = 1'b0;
        sdata_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset abandons any frame in flight.
  always_ff @(posedge CLK100MHz) begin
    if (RESET) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      sample_q  <= '0;
      last_q    <= '0;
      full_q    <= 1'b0;
      sdata_q   <= 1'b0;
      oe_q      <= 1'b0;
      fd_q      <= 1'b0;
      ur_q      <= 1'b0;
      ucnt_q    <= '0;
`ifdef AD7276_EMU_TEST_PATTERN_EN
      ramp_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      sample_q  <= sample_d;
      last_q    <= last_d;
      full_q    <= full_d;
      sdata_q   <= sdata_d;
      oe_q      <= oe_d;
      fd_q      <= fd_d;
      ur_q      <= ur_d;
      ucnt_q    <= ucnt_d;
`ifdef AD7276_EMU_TEST_PATTERN_EN
      ramp_q    <= ramp_d;
`endif
    end
  end

  assign sdata        = sdata_q;
  assign sdata_oe     = oe_q;
  assign busy         = (state_q != IDLE);
  assign frame_done   = fd_q;
  assign underrun     = ur_q;
  assign underrun_cnt = ucnt_q;

endmodule

// File: tb/tb_ad7276_emu.sv
// Directed self-checking bench for ad7276_emu: 100 MHz system clock, 25 MHz sclk
// emulated by the master; frames are sampled just before each sclk falling edge.
module tb_ad7276_emu;

  logic        CLK100MHz = 1'b0;
  logic        RESET;
  logic [11:0] s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic        cs;
  logic        sclk;
  logic        sdata;
  logic        sdata_oe;
  logic        busy;
  logic        frame_done;
  logic        underrun;
  logic [15:0] underrun_cnt;
`ifdef AD7276_EMU_TEST_PATTERN_EN
  logic        tp_en;
`endif

  int          vec_cnt = 0;
  int          err_cnt = 0;
  int          fd_seen = 0;
  int          ur_seen = 0;
  int          fd_base;
  int          ur_base;
  logic [15:0] bits;

  ad7276_emu dut (
    .CLK100MHz    (CLK100MHz),
    .RESET        (RESET),
`ifdef AD7276_EMU_TEST_PATTERN_EN
    .tp_en        (tp_en),
`endif
    .s_tdata      (s_tdata),
    .s_tvalid     (s_tvalid),
    .s_tready     (s_tready),
    .cs           (cs),
    .sclk         (sclk),
    .sdata        (sdata),
    .sdata_oe     (sdata_oe),
    .busy         (busy),
    .frame_done   (frame_done),
    .underrun     (underrun),
    .underrun_cnt (underrun_cnt)
  );

  always #5 CLK100MHz = ~CLK100MHz;

  // Pulse counters sampled mid-cycle.
  always @(negedge CLK100MHz) begin
    if (frame_done) fd_seen++;
    if (underrun) ur_seen++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge CLK100MHz);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vec_cnt++;
    assert (observed === expected) else begin
      err_cnt++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic cs_v, input logic sclk_v, input int cycles);
    cs   = cs_v;
    sclk = sclk_v;
    tick(cycles);
  endtask

  task automatic pushSample(input logic [11:0] v);
    s_tdata  = v;
    s_tvalid = 1'b1;
    tick(1);
    s_tvalid = 1'b0;
    tick(1);
  endtask

  task automatic shiftBits(input int n_falls, output logic [15:0] got);
    got = '0;
    for (int i = 0; i < n_falls; i++) begin
      if (i < 16) got[15-i] = sdata;
      applyStimulus(1'b0, 1'b0, 2);
      applyStimulus(1'b0, 1'b1, 2);
    end
  endtask

  task automatic fullFrame(output logic [15:0] got);
    applyStimulus(1'b0, 1'b1, 6);
    shiftBits(16, got);
    applyStimulus(1'b1, 1'b1, 6);
  endtask

  initial begin
    logic [15:0] exp_bits;

    RESET    = 1'b1;
    cs       = 1'b1;
    sclk     = 1'b1;
    s_tvalid = 1'b0;
    s_tdata  = '0;
`ifdef AD7276_EMU_TEST_PATTERN_EN
    tp_en    = 1'b0;
`endif
    tick(3);
    RESET = 1'b0;
    tick(2);

    $display("[TB] reset state");
    checkOutput("rst_sdata", 32'(sdata), 32'h0);
    checkOutput("rst_oe", 32'(sdata_oe), 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    checkOutput("rst_ready", 32'(s_tready), 32'h1);
    checkOutput("rst_cnt", 32'(underrun_cnt), 32'h0);

    $display("[TB] normal frame 12'hA5C");
    pushSample(12'hA5C);
    checkOutput("push_ready", 32'(s_tready), 32'h0);
    fd_base = fd_seen;
    ur_base = ur_seen;
    applyStimulus(1'b0, 1'b1, 6);
    checkOutput("frame_busy", 32'(busy), 32'h1);
    checkOutput("frame_oe", 32'(sdata_oe), 32'h1);
    shiftBits(16, bits);
    applyStimulus(1'b1, 1'b1, 6);
    checkOutput("normal_bits", 32'(bits), 32'h2970);
    checkOutput("normal_fd", 32'(fd_seen - fd_base), 32'd1);
    checkOutput("normal_ur", 32'(ur_seen - ur_base), 32'd0);
    checkOutput("normal_oe_end", 32'(sdata_oe), 32'h0);
    checkOutput("normal_busy_end", 32'(busy), 32'h0);
    checkOutput("normal_ready_end", 32'(s_tready), 32'h1);

    $display("[TB] two underrun frames");
    ur_base = ur_seen;
    fullFrame(bits);
    checkOutput("ur1_bits", 32'(bits), 32'h2970);
    fullFrame(bits);
    checkOutput("ur2_bits", 32'(bits), 32'h2970);
    checkOutput("ur_pulses", 32'(ur_seen - ur_base), 32'd2);
    checkOutput("ur_cnt", 32'(underrun_cnt), 32'd2);

    $display("[TB] bypass 12'h123");
    ur_base = ur_seen;
    applyStimulus(1'b0, 1'b1, 3);
    s_tdata  = 12'h123;
    s_tvalid = 1'b1;
    tick(1);
    s_tvalid = 1'b0;
    tick(2);
    checkOutput("bypass_ready", 32'(s_tready), 32'h1);
    shiftBits(16, bits);
    applyStimulus(1'b1, 1'b1, 6);
    checkOutput("bypass_bits", 32'(bits), 32'h048C);
    checkOutput("bypass_ur", 32'(ur_seen - ur_base), 32'd0);
    checkOutput("bypass_cnt", 32'(underrun_cnt), 32'd2);

    $display("[TB] aborted frame");
    pushSample(12'h3C7);
    fd_base = fd_seen;
    applyStimulus(1'b0, 1'b1, 6);
    shiftBits(6, bits);
    applyStimulus(1'b1, 1'b1, 6);
    checkOutput("abort_bits", 32'(bits[15:10]), 32'h03);
    checkOutput("abort_busy", 32'(busy), 32'h0);
    checkOutput("abort_oe", 32'(sdata_oe), 32'h0);
    checkOutput("abort_fd", 32'(fd_seen - fd_base), 32'd0);
    pushSample(12'h5A1);
    fd_base = fd_seen;
    fullFrame(bits);
    checkOutput("after_abort_bits", 32'(bits), 32'h1684);
    checkOutput("after_abort_fd", 32'(fd_seen - fd_base), 32'd1);

    $display("[TB] reset mid-frame");
    pushSample(12'hFFF);
    applyStimulus(1'b0, 1'b1, 6);
    shiftBits(10, bits);
    pushSample(12'h0F0);
    checkOutput("pre_rst_sdata", 32'(sdata), 32'h1);
    checkOutput("pre_rst_ready", 32'(s_tready), 32'h0);
    RESET = 1'b1;
    tick(1);
    checkOutput("mid_rst_sdata", 32'(sdata), 32'h0);
    checkOutput("mid_rst_oe", 32'(sdata_oe), 32'h0);
    checkOutput("mid_rst_busy", 32'(busy), 32'h0);
    checkOutput("mid_rst_fd", 32'(frame_done), 32'h0);
    checkOutput("mid_rst_ur", 32'(underrun), 32'h0);
    checkOutput("mid_rst_cnt", 32'(underrun_cnt), 32'h0);
    checkOutput("mid_rst_ready", 32'(s_tready), 32'h1);
    cs = 1'b1;
    tick(4);
    RESET = 1'b0;
    tick(4);
    checkOutput("post_rst_busy", 32'(busy), 32'h0);
    ur_base = ur_seen;
    fd_base = fd_seen;
    fullFrame(bits);
    checkOutput("post_rst_bits", 32'(bits), 32'h0000);
    checkOutput("post_rst_ur", 32'(ur_seen - ur_base), 32'd1);
    checkOutput("post_rst_cnt", 32'(underrun_cnt), 32'd1);
    checkOutput("post_rst_fd", 32'(fd_seen - fd_base), 32'd1);

`ifdef AD7276_EMU_TEST_PATTERN_EN
    $display("[TB] test pattern ramp");
    tp_en = 1'b1;
    tick(1);
    checkOutput("tp_ready", 32'(s_tready), 32'h0);
    ur_base = ur_seen;
    for (int f = 0; f < 4097; f++) begin
      if (f < 2 || f >= 4095) begin
        fullFrame(bits);
        exp_bits = {2'b00, 12'(f), 2'b00};
        checkOutput("tp_bits", 32'(bits), 32'(exp_bits));
      end else begin
        applyStimulus(1'b0, 1'b1, 5);
        applyStimulus(1'b1, 1'b1, 5);
      end
    end
    checkOutput("tp_ur", 32'(ur_seen - ur_base), 32'd0);
    tp_en = 1'b0;
`else
    exp_bits = '0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
